// File: rtl/turbosim_iter_ctrl.sv
// Iteration controller for the turbosim core: stages host input-change records, loads them
// into the core, sequences go/done, drains output changes and reports per-iteration counts.
module turbosim_iter_ctrl #(
  parameter int REC_W   = 32,
  parameter int DEPTH   = 64,
  parameter int GO_CYC  = 1,
  parameter int TIMEOUT = 65535,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [REC_W-1:0] s_data,
  input  logic             s_last,
  output logic             ts_wr,
  input  logic             ts_full,
  output logic [REC_W-1:0] ts_in_record,
  output logic             ts_go,
  input  logic             ts_done,
  output logic             ts_rd,
  input  logic             ts_empty,
  input  logic [REC_W-1:0] ts_out_record,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [REC_W-1:0] m_data,
  output logic             busy,
  output logic             iter_done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] change_count,
  output logic [CNT_W-1:0] iter_count,
  output logic             timeout_err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [3:0] ST_INIT  = 4'd0;
  localparam logic [3:0] ST_IDLE  = 4'd1;
  localparam logic [3:0] ST_LOAD  = 4'd2;
  localparam logic [3:0] ST_GO    = 4'd3;
  localparam logic [3:0] ST_ARM   = 4'd4;
  localparam logic [3:0] ST_RUN   = 4'd5;
  localparam logic [3:0] ST_DRAIN = 4'd6;
  localparam logic [3:0] ST_ABORT = 4'd7;
  localparam logic [3:0] ST_END   = 4'd8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  logic [REC_W:0]   mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             stage_full_s;
  logic             stage_empty_s;
  logic             push_s;
  logic             pop_s;
  logic [REC_W:0]   head_s;
  logic [3:0]       state_r;
  logic [3:0]       state_nx_s;
  logic [31:0]      tmr_r;
  logic             timeout_hit_s;
  logic [CNT_W-1:0] cyc_r;
  logic [CNT_W-1:0] chg_r;
  logic             ts_go_r;
  logic             busy_r;
  logic             iter_done_r;
  logic [CNT_W-1:0] cycle_count_r;
  logic [CNT_W-1:0] change_count_r;
  logic [CNT_W-1:0] iter_count_r;
  logic             timeout_err_r;

  assign stage_full_s  = (count_r == (AW+1)'(DEPTH));
  assign stage_empty_s = (count_r == {(AW+1){1'b0}});
  assign head_s        = mem_r[rd_ptr_r];
  assign s_ready       = !stage_full_s;
  assign push_s        = s_valid && !stage_full_s;
  assign ts_wr         = (state_r == ST_LOAD) && !stage_empty_s && !ts_full;
  assign pop_s         = ts_wr;
  assign ts_in_record  = head_s[REC_W-1:0];
  assign ts_rd         = !ts_empty && m_ready;
  assign m_valid       = !ts_empty;
  assign m_data        = ts_out_record;
  // tmr_r restarts on every state change, so it measures time spent in the current state
  assign timeout_hit_s = (TIMEOUT != 0) && (tmr_r == 32'(TIMEOUT - 1));

  assign ts_go        = ts_go_r;
  assign busy         = busy_r;
  assign iter_done    = iter_done_r;
  assign cycle_count  = cycle_count_r;
  assign change_count = change_count_r;
  assign iter_count   = iter_count_r;
  assign timeout_err  = timeout_err_r;

  // Staging FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {s_last, s_data};
    end
  end

  // Staging FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Iteration sequencing
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_INIT:  if (ts_done) state_nx_s = ST_IDLE; else state_nx_s = state_r;
      ST_IDLE:  if (!stage_empty_s) state_nx_s = ST_LOAD; else state_nx_s = state_r;
      ST_LOAD:  if (pop_s && head_s[REC_W]) state_nx_s = ST_GO; else state_nx_s = state_r;
      ST_GO:    if (tmr_r == 32'(GO_CYC - 1)) state_nx_s = ST_ARM; else state_nx_s = state_r;
      ST_ARM: begin
        if (!ts_done)           state_nx_s = ST_RUN;
        else if (timeout_hit_s) state_nx_s = ST_ABORT;
        else                    state_nx_s = state_r;
      end
      ST_RUN: begin
        if (ts_done)            state_nx_s = ST_DRAIN;
        else if (timeout_hit_s) state_nx_s = ST_ABORT;
        else                    state_nx_s = state_r;
      end
      ST_DRAIN: if (ts_empty) state_nx_s = ST_END; else state_nx_s = state_r;
      ST_ABORT: state_nx_s = ST_END;
      ST_END:   state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_INIT;
    endcase
  end

  // State, timers, running counters and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_INIT;
      tmr_r          <= 32'd0;
      cyc_r          <= {CNT_W{1'b0}};
      chg_r          <= {CNT_W{1'b0}};
      ts_go_r        <= 1'b0;
      busy_r         <= 1'b0;
      iter_done_r    <= 1'b0;
      cycle_count_r  <= {CNT_W{1'b0}};
      change_count_r <= {CNT_W{1'b0}};
      iter_count_r   <= {CNT_W{1'b0}};
      timeout_err_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      tmr_r   <= (state_nx_s != state_r) ? 32'd0 : tmr_r + 32'd1;
      if (state_r == ST_IDLE) begin
        cyc_r <= {CNT_W{1'b0}};
        chg_r <= {CNT_W{1'b0}};
      end else begin
        if (state_r == ST_RUN) cyc_r <= sat_inc(cyc_r);
        if (ts_rd)             chg_r <= sat_inc(chg_r);
      end
      ts_go_r     <= (state_nx_s == ST_GO);
      busy_r      <= (state_nx_s != ST_IDLE) && (state_nx_s != ST_INIT);
      iter_done_r <= (state_r == ST_END);
      // counts become visible together with the iter_done pulse
      if (state_r == ST_END) begin
        cycle_count_r  <= cyc_r;
        change_count_r <= ts_rd ? sat_inc(chg_r) : chg_r;
        iter_count_r   <= sat_inc(iter_count_r);
      end
      if (state_r == ST_ABORT) timeout_err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_turbosim_iter_ctrl.sv
// Directed self-checking bench for turbosim_iter_ctrl with a small behavioural core model
// for the output FIFO; DEPTH=4 and TIMEOUT=50 so fill and timeout corners are reachable.
module tb_turbosim_iter_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, s_last;
  logic [31:0] s_data;
  logic        ts_wr, ts_full, ts_go, ts_done, ts_rd, ts_empty;
  logic [31:0] ts_in_record, ts_out_record, m_data;
  logic        m_valid, m_ready, busy, iter_done, timeout_err;
  logic [15:0] cycle_count, change_count, iter_count;

  int tests_run = 0;
  int tests_failed = 0;
  int out_push = 0;
  int out_pop = 0;
  int go_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  logic [31:0] wr_log[$];
  logic [31:0] rd_log[$];
  logic [31:0] rec1[3];
  logic [31:0] rec6[4];
  logic [31:0] rec5;
  int snap;

  turbosim_iter_ctrl #(.REC_W(32), .DEPTH(4), .GO_CYC(1), .TIMEOUT(50), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .ts_wr(ts_wr), .ts_full(ts_full), .ts_in_record(ts_in_record),
    .ts_go(ts_go), .ts_done(ts_done), .ts_rd(ts_rd), .ts_empty(ts_empty),
    .ts_out_record(ts_out_record), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .iter_done(iter_done), .cycle_count(cycle_count),
    .change_count(change_count), .iter_count(iter_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // core output FIFO model: out_push records made available, popped on ts_rd
  assign ts_empty      = (out_pop >= out_push);
  assign ts_out_record = {2'b10, 14'(out_pop), 16'(out_pop * 3)};

  always @(posedge clk) begin
    if (ts_wr) wr_log.push_back(ts_in_record);
    if (ts_rd) begin
      rd_log.push_back(m_data);
      out_pop <= out_pop + 1;
      rd_cnt  <= rd_cnt + 1;
    end
    if (ts_go)     go_cnt   <= go_cnt + 1;
    if (iter_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] rec, input logic last);
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = rec; s_last = last;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_go(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ts_go) break;
    end
    check(tag, 32'(ts_go), 32'd1);
  endtask

  task automatic wait_iter(input string tag);
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (iter_done) break;
    end
    check(tag, 32'(iter_done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rec1[0] = {2'b01, 14'd5,   16'd100};
    rec1[1] = {2'b00, 14'd17,  16'd101};
    rec1[2] = {2'b11, 14'd300, 16'd102};
    rec5    = {2'b10, 14'd42,  16'd7};
    for (int i = 0; i < 4; i++) rec6[i] = {2'b01, 14'(i + 60), 16'(i * 10)};

    rst = 1'b1; s_valid = 1'b0; s_data = 32'd0; s_last = 1'b0;
    ts_full = 1'b0; ts_done = 1'b1; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_go_wr", {30'd0, ts_go, ts_wr}, 32'd0);
    check("rst_counts", {iter_count, cycle_count}, 32'd0);
    check("rst_err_done", {30'd0, timeout_err, iter_done}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // batch of three with the core input FIFO full during LOAD
    ts_full = 1'b1;
    push(rec1[0], 1'b0);
    push(rec1[1], 1'b0);
    push(rec1[2], 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("full_no_wr", 32'(ts_wr), 32'd0);
      check("full_head", ts_in_record, rec1[0]);
    end
    @(posedge clk); #1 ts_full = 1'b0;
    wait_go("go1_seen");
    check("load_n", 32'(wr_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) check("load_order", wr_log[i], rec1[i]);
    snap = go_cnt;

    // core drops done, runs 40 cycles, then offers 7 outputs with m_ready held low
    @(posedge clk);
    @(negedge clk);
    check("go1_width", 32'(ts_go), 32'd0);
    check("go1_count", 32'(go_cnt - snap), 32'd1);
    @(posedge clk); #1 ts_done = 1'b0;
    repeat (40) @(posedge clk);
    #1 ts_done = 1'b1; out_push = 7; m_ready = 1'b0;
    snap = rd_cnt;
    repeat (10) @(negedge clk);
    check("bp_no_rd", 32'(rd_cnt - snap), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    check("bp_m_valid", 32'(m_valid), 32'd1);
    @(posedge clk); #1 m_ready = 1'b1;
    snap = done_cnt;
    wait_iter("it1_done");
    check("it1_cycles", 32'(cycle_count), 32'd40);
    check("it1_changes", 32'(change_count), 32'd7);
    check("it1_iters", 32'(iter_count), 32'd1);
    check("it1_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("it1_pulse", 32'(done_cnt - snap), 32'd1);
    check("drain_n", 32'(rd_log.size()), 32'd7);
    for (int i = 0; i < 7; i++) check("drain_data", rd_log[i], {2'b10, 14'(i), 16'(i * 3)});

    // lone last record; core accepts go and never finishes -> timeout
    push(rec5, 1'b1);
    wait_go("go2_seen");
    @(posedge clk); #1 ts_done = 1'b0;
    // prefetch the next batch while RUN: FIFO of 4 fills up
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = rec6[i]; s_last = (i == 3);
      @(negedge clk);
      check("fill_ready", 32'(s_ready), 32'd1);
    end
    @(posedge clk); #1 s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    check("fill_full", 32'(s_ready), 32'd0);
    check("fill_no_wr", 32'(ts_wr), 32'd0);
    wait_iter("it2_done");
    check("it2_err", 32'(timeout_err), 32'd1);
    check("it2_cycles", 32'(cycle_count), 32'd50);
    check("it2_iters", 32'(iter_count), 32'd2);
    check("it2_busy", 32'(busy), 32'd0);

    // prefetched batch loads after END; core runs a single cycle
    wait_go("go3_seen");
    check("load3_n", 32'(wr_log.size()), 32'd8);
    check("load3_single", wr_log[3], rec5);
    for (int i = 0; i < 4; i++) check("load3_order", wr_log[4 + i], rec6[i]);
    check("load3_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    @(posedge clk); #1 ts_done = 1'b1;
    wait_iter("it3_done");
    check("it3_cycles", 32'(cycle_count), 32'd1);
    check("it3_iters", 32'(iter_count), 32'd3);
    check("it3_err_sticky", 32'(timeout_err), 32'd1);

    // reset in the middle of a stalled LOAD flushes everything
    ts_full = 1'b1;
    push(rec1[0], 1'b0);
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; ts_full = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_status", {iter_count, 14'd0, timeout_err, s_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_flushed", {30'd0, ts_wr, ts_go}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
